// File: rtl/r_inst_pkg.sv
// Shared definitions for the R-type execute sequencer.
// Contents: ALU operation codes, R-type funct codes, the R-type opcode,
// the sequencer state encoding, the default datapath width and the
// funct -> ALU operation decoder.
// ALU operation 3'b011 (XNOR) is reserved: no funct code maps to it.
package r_inst_pkg;

    localparam int DW_DEF = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       illegal;
        logic       is_arith;   // add/sub: the only ops whose OF is meaningful
    } dec_t;

    // Undecodable words fall back to AND so the ALU still produces flags.
    function automatic dec_t decode_funct(input logic [5:0] op, input logic [5:0] funct);
        dec_t d;
        d.alu_op   = OP_AND;
        d.illegal  = 1'b0;
        d.is_arith = 1'b0;
        if (op != OPC_RTYPE) begin
            d.illegal = 1'b1;
        end else begin
            case (funct)
                FN_ADD:  begin d.alu_op = OP_ADD; d.is_arith = 1'b1; end
                FN_SUB:  begin d.alu_op = OP_SUB; d.is_arith = 1'b1; end
                FN_AND:  d.alu_op = OP_AND;
                FN_OR:   d.alu_op = OP_OR;
                FN_XOR:  d.alu_op = OP_XOR;
                FN_SLTU: d.alu_op = OP_SLTU;
                FN_SLLV: d.alu_op = OP_SLL;
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/r_type_exec_ctrl_reg_file.sv
// reg_file_32x32: general-purpose register file for the R-type sequencer.
// Ports: clk, rst (async, active-high, clears every entry);
//        addr_en latches rd_addr_a/rd_addr_b into the read-address registers;
//        rd_data_a/rd_data_b read through those registered addresses;
//        dbg_addr/dbg_data is a purely combinational debug read;
//        wr_en/wr_addr/wr_data is the single write port.
// Entry 0 is hard-wired to zero: writes to it are dropped, reads return 0.
module reg_file_32x32 #(
    parameter int RF_DEPTH = 32,
    parameter int DW       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        addr_en,
    input  logic [$clog2(RF_DEPTH)-1:0] rd_addr_a,
    input  logic [$clog2(RF_DEPTH)-1:0] rd_addr_b,
    output logic [DW-1:0]               rd_data_a,
    output logic [DW-1:0]               rd_data_b,
    input  logic [$clog2(RF_DEPTH)-1:0] dbg_addr,
    output logic [DW-1:0]               dbg_data,
    input  logic                        wr_en,
    input  logic [$clog2(RF_DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]               wr_data
);

    localparam int AW = $clog2(RF_DEPTH);

    logic [DW-1:0] mem_r [RF_DEPTH];
    logic [AW-1:0] addr_a_r;
    logic [AW-1:0] addr_b_r;

    // Read-address registers, loaded when an instruction is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a_r <= {AW{1'b0}};
            addr_b_r <= {AW{1'b0}};
        end else if (addr_en) begin
            addr_a_r <= rd_addr_a;
            addr_b_r <= rd_addr_b;
        end
    end

    // Storage array; entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (addr_a_r == {AW{1'b0}}) ? {DW{1'b0}} : mem_r[addr_a_r];
    assign rd_data_b = (addr_b_r == {AW{1'b0}}) ? {DW{1'b0}} : mem_r[addr_b_r];
    assign dbg_data  = (dbg_addr == {AW{1'b0}}) ? {DW{1'b0}} : mem_r[dbg_addr];

endmodule

// File: rtl/r_type_exec_ctrl.sv
// r_type_exec_ctrl: multi-cycle sequencer executing one MIPS R-type
// instruction at a time in front of an external combinational ALU.
// Flow: IDLE (accept) -> READ (operands, decode) -> EXEC (ALU settles,
// result/flags captured) -> WB (done pulse, write rd) -> IDLE.
// Ports: clk, rst (async, active-high); inst/inst_valid/inst_ready handshake;
//        A/B/ALU_OP drive the ALU, F/ZF/OF return from it;
//        done/illegal retire pulses; zf_q/of_q flags of last instruction;
//        dbg_addr/dbg_data combinational register-file peek.
// Build option OF_TRAP_EN: when defined, add/sub that overflow skip the
// write-back and set the sticky output ovf_trap (cleared only by rst).
module r_type_exec_ctrl
    import r_inst_pkg::*;
#(
    parameter int RF_DEPTH = 32,
    parameter int DW       = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   inst,
    input  logic          inst_valid,
    output logic          inst_ready,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [2:0]    ALU_OP,
    input  logic [DW-1:0] F,
    input  logic          ZF,
    input  logic          OF,
    output logic          done,
    output logic          illegal,
    output logic          zf_q,
    output logic          of_q,
`ifdef OF_TRAP_EN
    output logic          ovf_trap,
`endif
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        state_r;
    state_t        next_state_s;
    logic [31:0]   inst_r;
    logic          accept_s;
    dec_t          dec_s;
    logic [DW-1:0] rd_a_s;
    logic [DW-1:0] rd_b_s;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [2:0]    alu_op_r;
    logic          ill_pend_r;
    logic [DW-1:0] res_r;
    logic          zf_r;
    logic          of_r;
    logic          done_r;
    logic          illegal_r;
    logic          ready_r;
    logic          wr_en_s;
    logic          blk_s;
    logic          unused_shamt_s;

    assign accept_s       = inst_valid & ready_r;
    assign dec_s          = decode_funct(inst_r[31:26], inst_r[5:0]);
    assign unused_shamt_s = ^inst_r[10:6];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: fixed four-step walk, only IDLE waits.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: next_state_s = ST_EXEC;
            ST_EXEC: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Instruction latch, operand/result registers and retire pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r     <= 32'h0000_0000;
            a_r        <= {DW{1'b0}};
            b_r        <= {DW{1'b0}};
            alu_op_r   <= OP_AND;
            ill_pend_r <= 1'b0;
            res_r      <= {DW{1'b0}};
            zf_r       <= 1'b0;
            of_r       <= 1'b0;
            done_r     <= 1'b0;
            illegal_r  <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            if (accept_s) begin
                inst_r <= inst;
            end
            if (state_r == ST_READ) begin
                a_r        <= rd_a_s;
                b_r        <= rd_b_s;
                alu_op_r   <= dec_s.alu_op;
                ill_pend_r <= dec_s.illegal;
            end
            if (state_r == ST_EXEC) begin
                res_r <= F;
                zf_r  <= ZF;
                of_r  <= OF;
            end
            // Pulses and ready are registered from the next state so they
            // line up exactly with the state they describe.
            done_r    <= (next_state_s == ST_WB);
            illegal_r <= (next_state_s == ST_WB) & ill_pend_r;
            ready_r   <= (next_state_s == ST_IDLE);
        end
    end

`ifdef OF_TRAP_EN
    logic arith_r;
    logic trap_r;

    // Overflow trap: remembers add/sub-ness and latches a sticky trap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arith_r <= 1'b0;
            trap_r  <= 1'b0;
        end else begin
            if (state_r == ST_READ) begin
                arith_r <= dec_s.is_arith;
            end
            if ((state_r == ST_EXEC) && arith_r && OF) begin
                trap_r <= 1'b1;
            end
        end
    end

    assign blk_s    = arith_r & of_r;
    assign ovf_trap = trap_r;
`else
    logic unused_arith_s;
    assign unused_arith_s = dec_s.is_arith;
    assign blk_s          = 1'b0;
`endif

    assign wr_en_s = (state_r == ST_WB) & ~ill_pend_r & ~blk_s;

    reg_file_32x32 #(
        .RF_DEPTH (RF_DEPTH),
        .DW       (DW)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .addr_en   (accept_s),
        .rd_addr_a (inst[25:21]),
        .rd_addr_b (inst[20:16]),
        .rd_data_a (rd_a_s),
        .rd_data_b (rd_b_s),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en_s),
        .wr_addr   (inst_r[15:11]),
        .wr_data   (res_r)
    );

    assign inst_ready = ready_r;
    assign A          = a_r;
    assign B          = b_r;
    assign ALU_OP     = alu_op_r;
    assign done       = done_r;
    assign illegal    = illegal_r;
    assign zf_q       = zf_r;
    assign of_q       = of_r;

endmodule
